stk_ptr_alloc: RTL and testbench
================================

Name: stk_ptr_alloc

Overview:
- Free-list pointer allocator for the stack pipeline.
- Sits upstream of the LK stage and drives its allocation interface (i_lk_ptr), supplying one free line pointer per PUSH.
- Returns lines to the pool when POP/INV retire them.
- Keeps a circular FIFO of free pointers, an in-use bitmap for double-free/invalid-free detection, and a power-on initialisation sequencer.

Parameters:
- LINES_N, 64, number of allocatable lines; power of two, ≥4.
- PTR_W, $clog2(LINES_N), pointer width; must equal stk_pkg::PTR_W (elaboration assertion).

Ports:
- clk  in  1  clock.
- arst_n  in  1  asynchronous active-low reset.
- o_init_done_r  out  1  high once the free list is populated; stays high until reset.
- o_alloc_vld  out  1  a free pointer is available (init done and count != 0).
- o_alloc_ptr  out  PTR_W  current head of free list; valid when o_alloc_vld; feeds i_lk_ptr.
- i_alloc  in  1  consume o_alloc_ptr this cycle (PUSH in LK).
- i_free_vld  in  1  return a pointer this cycle.
- i_free_ptr  in  PTR_W  pointer being returned.
- o_free_cnt_r  out  PTR_W+1  number of free pointers.
- o_err_r  out  1  sticky error flag.
- o_err_code_r  out  2  first error cause: 0 none, 1 alloc-on-empty, 2 free of unallocated ptr, 3 free during init.

Behaviour:
- Storage:
  - fifo[LINES_N] of PTR_W flops; rd_ptr/wr_ptr are PTR_W bits each and wrap naturally modulo LINES_N.
  - inuse[LINES_N] bitmap; cnt is PTR_W+1 bits.
- Reset values: rd_ptr=0, wr_ptr=0, cnt=0, inuse='0, state=INIT, init_idx=0, o_init_done_r=0, o_err_r=0, o_err_code_r=0. The fifo contents are not reset.
- Outputs during reset: o_alloc_vld=0, o_alloc_ptr=0 (forced to 0 while !o_alloc_vld).
- FSM INIT:
  - One pointer is written per cycle: fifo[init_idx]=init_idx, wr_ptr++, cnt++, init_idx++.
  - After LINES_N cycles (init_idx wraps to 0), go to RUN and set o_init_done_r.
  - Following reset deassertion, cnt reaches LINES_N exactly LINES_N cycles later and o_alloc_vld rises the same cycle.
- INIT input handling:
  - i_alloc is ignored in INIT.
  - i_free_vld in INIT is dropped and raises error 3.
- FSM RUN:
  - Terminal state; only reset leaves it.
  - Allocate fires when i_alloc & o_alloc_vld: rd_ptr++, inuse[o_alloc_ptr]<=1.
  - Free fires when i_free_vld & inuse[i_free_ptr]: fifo[wr_ptr]<=i_free_ptr, wr_ptr++, inuse[i_free_ptr]<=0.
- Count update:
  - cnt += free_fire - alloc_fire.
  - Simultaneous alloc and free leaves cnt unchanged; both pointers advance.
- Read latency:
  - o_alloc_ptr is a combinational read of fifo[rd_ptr].
  - A freed pointer becomes allocatable no earlier than the next cycle; there is no same-cycle bypass.
  - Simultaneous free into an empty list gives o_alloc_vld=0 that cycle and 1 the next.
- Same-pointer case: alloc and free of the same ptr in one cycle is impossible, since that ptr cannot be both free-list head and in use.
- Error handling:
  - i_alloc while !o_alloc_vld in RUN gives error 1, no state change.
  - i_free_vld with inuse[i_free_ptr]=0 gives error 2, free dropped.
  - Errors are sticky and first-cause only: o_err_code_r latches only while o_err_r=0.
  - Errors do not block further operation.
- Full: cnt==LINES_N implies inuse is all zero; a free is therefore always error 2, so overflow is unreachable.
- Reset mid-operation: all state returns to its reset values and INIT reruns; outstanding allocations are forgotten.
- Assertions:
  - cnt <= LINES_N.
  - cnt == LINES_N - popcount(inuse) in RUN.
  - o_alloc_ptr is never in use while o_alloc_vld.

Decomposition:
- stk_pkg holds: ptr_t (PTR_W), LINES_N, and the alloc_err_t enum (NONE, ALLOC_EMPTY, FREE_UNALLOC, FREE_INIT).
- The FSM state enum {INIT, RUN} is local to the module.
- One sub-module: stk_ptr_alloc_fifo. It is the circular pointer FIFO (storage, rd/wr pointers, count) with push/pop and an init-write port.
- The bitmap, FSM and error logic stay in the top module.

Test Plan:
- Reset, then idle with LINES_N=64 -> o_alloc_vld rises exactly 64 cycles after reset deassertion; o_free_cnt_r=64; o_alloc_ptr=0.
- Back-to-back i_alloc for 64 cycles -> pointers 0,1,…,63 issued in order; then o_alloc_vld=0, cnt=0; a 65th i_alloc sets o_err_r=1, code=1.
- Allocate 0..3, free 2 then 0, then drain the list -> after ptrs 4..63 the next allocations are 2 then 0 (FIFO order, wrap of rd_ptr/wr_ptr).
- Simultaneous i_alloc and i_free_vld(ptr=5, previously allocated) at cnt=10 -> cnt stays 10; inuse[5]=0; fifo tail holds 5.
- Double free: free ptr 7 twice -> first accepted; second sets err code 2, cnt unchanged. A later alloc-on-empty leaves the code at 2 (first-cause).
- i_free_vld during INIT (cycle 10 after reset), plus assert arst_n=0 mid-RUN with cnt=20 -> code 3 during INIT; after re-reset cnt=0, err cleared, INIT reruns for 64 cycles.

Source files
------------

// File: rtl/stk_pkg.sv
// Shared types for the stack pipeline: pointer width, line count and allocator error causes.
package stk_pkg;

  localparam int unsigned LINES_N = 64;
  localparam int unsigned PTR_W   = $clog2(LINES_N);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [PTR_W:0]   cnt_t;

  typedef enum logic [1:0] {
    ErrNone        = 2'd0,
    ErrAllocEmpty  = 2'd1,
    ErrFreeUnalloc = 2'd2,
    ErrFreeInit    = 2'd3
  } alloc_err_t;

endpackage

// File: rtl/stk_ptr_alloc_if.sv
// Allocation/free handshake between the pointer allocator and the LK stage.
interface stk_ptr_alloc_if;
  import stk_pkg::*;

  logic       o_init_done_r;
  logic       o_alloc_vld;
  ptr_t       o_alloc_ptr;
  logic       i_alloc;
  logic       i_free_vld;
  ptr_t       i_free_ptr;
  cnt_t       o_free_cnt_r;
  logic       o_err_r;
  alloc_err_t o_err_code_r;

  modport slave (
    output o_init_done_r, o_alloc_vld, o_alloc_ptr, o_free_cnt_r, o_err_r, o_err_code_r,
    input  i_alloc, i_free_vld, i_free_ptr
  );

  modport master (
    input  o_init_done_r, o_alloc_vld, o_alloc_ptr, o_free_cnt_r, o_err_r, o_err_code_r,
    output i_alloc, i_free_vld, i_free_ptr
  );

endinterface

// File: rtl/stk_ptr_alloc_fifo.sv
// Circular FIFO of free line pointers with a count; init writes and pushes share the tail.
module stk_ptr_alloc_fifo #(
  parameter int unsigned LINES_N = 64,
  parameter int unsigned PTR_W   = $clog2(LINES_N)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             init_we_i,
  input  logic [PTR_W-1:0] init_data_i,
  input  logic             push_i,
  input  logic [PTR_W-1:0] push_data_i,
  input  logic             pop_i,
  output logic [PTR_W-1:0] rd_data_o,
  output logic [PTR_W:0]   cnt_o
);

  logic [PTR_W-1:0] mem_q [LINES_N];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             we;
  logic [PTR_W-1:0] wdata;

  // Init writes and pushes never coincide: pushes only happen after init completes.
  always_comb begin
    we       = init_we_i | push_i;
    wdata    = init_we_i ? init_data_i : push_data_i;
    wr_ptr_d = wr_ptr_q + PTR_W'(we);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
    cnt_d    = cnt_q + (PTR_W+1)'(we) - (PTR_W+1)'(pop_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign cnt_o     = cnt_q;

endmodule

// File: rtl/stk_ptr_alloc.sv
// Free-list line pointer allocator: populates the list after reset, hands out pointers
// on PUSH, takes them back on POP/INV and flags illegal requests.
module stk_ptr_alloc #(
  parameter int unsigned LINES_N = 64,
  parameter int unsigned PTR_W   = $clog2(LINES_N)
) (
  input logic                clk,
  input logic                arst_n,
  stk_ptr_alloc_if.slave     alloc_io
);
  import stk_pkg::*;

  if ((PTR_W != stk_pkg::PTR_W) || (LINES_N < 4) || ((LINES_N & (LINES_N - 1)) != 0))
  begin : g_param_check
    $error("stk_ptr_alloc: LINES_N must be a power of two >= 4 matching stk_pkg::PTR_W");
  end

  typedef enum logic {StInit, StRun} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   init_idx_q, init_idx_d;
  logic [LINES_N-1:0] inuse_q, inuse_d;
  logic               init_done_q, init_done_d;
  logic               err_q, err_d;
  alloc_err_t         err_code_q, err_code_d;

  logic               run;
  logic               alloc_vld;
  logic               alloc_fire;
  logic               free_fire;
  logic               init_we;
  logic [PTR_W-1:0]   rd_data;
  logic [PTR_W:0]     cnt;

  stk_ptr_alloc_fifo #(
    .LINES_N (LINES_N),
    .PTR_W   (PTR_W)
  ) u_fifo (
    .clk_i       (clk),
    .rst_ni      (arst_n),
    .init_we_i   (init_we),
    .init_data_i (init_idx_q),
    .push_i      (free_fire),
    .push_data_i (alloc_io.i_free_ptr),
    .pop_i       (alloc_fire),
    .rd_data_o   (rd_data),
    .cnt_o       (cnt)
  );

  always_comb begin
    run        = (state_q == StRun);
    alloc_vld  = init_done_q && (cnt != '0);
    alloc_fire = alloc_io.i_alloc && alloc_vld;
    free_fire  = run && alloc_io.i_free_vld && inuse_q[alloc_io.i_free_ptr];
  end

  always_comb begin
    state_d     = state_q;
    init_idx_d  = init_idx_q;
    init_done_d = init_done_q;
    init_we     = 1'b0;
    inuse_d     = inuse_q;
    err_d       = err_q;
    err_code_d  = err_code_q;

    unique case (state_q)
      StInit: begin
        init_we    = 1'b1;
        init_idx_d = init_idx_q + 1'b1;
        if (init_idx_q == PTR_W'(LINES_N - 1)) begin
          state_d     = StRun;
          init_done_d = 1'b1;
        end
      end
      StRun: begin
        // Alloc and free can never name the same pointer, so the order here is irrelevant.
        if (alloc_fire) inuse_d[rd_data] = 1'b1;
        if (free_fire)  inuse_d[alloc_io.i_free_ptr] = 1'b0;
      end
      default: state_d = StInit;
    endcase

    if (!err_q) begin
      if (!run && alloc_io.i_free_vld) begin
        err_d      = 1'b1;
        err_code_d = ErrFreeInit;
      end else if (run && alloc_io.i_alloc && !alloc_vld) begin
        err_d      = 1'b1;
        err_code_d = ErrAllocEmpty;
      end else if (run && alloc_io.i_free_vld && !inuse_q[alloc_io.i_free_ptr]) begin
        err_d      = 1'b1;
        err_code_d = ErrFreeUnalloc;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= StInit;
      init_idx_q  <= '0;
      inuse_q     <= '0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ErrNone;
    end else begin
      state_q     <= state_d;
      init_idx_q  <= init_idx_d;
      inuse_q     <= inuse_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign alloc_io.o_init_done_r = init_done_q;
  assign alloc_io.o_alloc_vld   = alloc_vld;
  assign alloc_io.o_alloc_ptr   = alloc_vld ? rd_data : '0;
  assign alloc_io.o_free_cnt_r  = cnt;
  assign alloc_io.o_err_r       = err_q;
  assign alloc_io.o_err_code_r  = err_code_q;

  a_cnt_bound: assert property (@(posedge clk) disable iff (!arst_n)
    int'(cnt) <= int'(LINES_N));
  a_cnt_matches_inuse: assert property (@(posedge clk) disable iff (!arst_n)
    run |-> (int'(cnt) == int'(LINES_N) - $countones(inuse_q)));
  a_head_not_inuse: assert property (@(posedge clk) disable iff (!arst_n)
    alloc_vld |-> !inuse_q[rd_data]);

endmodule

// File: tb/tb_stk_ptr_alloc.sv
// Directed bench for stk_ptr_alloc: init timing, FIFO ordering, simultaneous traffic,
// error causes and mid-run reset.
module tb_stk_ptr_alloc;
  import stk_pkg::*;

  logic clk;
  logic arst_n;
  int   n_checks;
  int   n_pass;

  stk_ptr_alloc_if alloc_if ();

  stk_ptr_alloc #(
    .LINES_N (64),
    .PTR_W   (6)
  ) dut (
    .clk      (clk),
    .arst_n   (arst_n),
    .alloc_io (alloc_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic reset_and_init();
    arst_n = 1'b0;
    #2;
    arst_n = 1'b1;
    repeat (64) step();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    arst_n   = 1'b0;
    alloc_if.i_alloc    = 1'b0;
    alloc_if.i_free_vld = 1'b0;
    alloc_if.i_free_ptr = '0;
    #12;

    // Reset state
    chk("rst_vld", 32'(alloc_if.o_alloc_vld), 0);
    chk("rst_ptr", 32'(alloc_if.o_alloc_ptr), 0);
    chk("rst_cnt", 32'(alloc_if.o_free_cnt_r), 0);
    chk("rst_done", 32'(alloc_if.o_init_done_r), 0);
    chk("rst_err", 32'(alloc_if.o_err_r), 0);
    chk("rst_code", 32'(alloc_if.o_err_code_r), 0);

    // Init takes exactly 64 cycles
    arst_n = 1'b1;
    repeat (63) step();
    chk("init63_vld", 32'(alloc_if.o_alloc_vld), 0);
    chk("init63_cnt", 32'(alloc_if.o_free_cnt_r), 63);
    step();
    chk("init64_vld", 32'(alloc_if.o_alloc_vld), 1);
    chk("init64_cnt", 32'(alloc_if.o_free_cnt_r), 64);
    chk("init64_ptr", 32'(alloc_if.o_alloc_ptr), 0);
    chk("init64_done", 32'(alloc_if.o_init_done_r), 1);

    // Back-to-back allocation drains 0..63 in order
    alloc_if.i_alloc = 1'b1;
    for (int i = 0; i < 64; i++) begin
      chk($sformatf("b2b_ptr%0d", i), 32'(alloc_if.o_alloc_ptr), 32'(i));
      step();
    end
    chk("empty_vld", 32'(alloc_if.o_alloc_vld), 0);
    chk("empty_cnt", 32'(alloc_if.o_free_cnt_r), 0);
    chk("empty_ptr", 32'(alloc_if.o_alloc_ptr), 0);
    step();
    alloc_if.i_alloc = 1'b0;
    chk("aempty_err", 32'(alloc_if.o_err_r), 1);
    chk("aempty_code", 32'(alloc_if.o_err_code_r), 1);
    chk("aempty_cnt", 32'(alloc_if.o_free_cnt_r), 0);

    // Allocate 0..3, free 2 then 0, drain: FIFO order across wrap
    reset_and_init();
    chk("re_err", 32'(alloc_if.o_err_r), 0);
    alloc_if.i_alloc = 1'b1;
    repeat (4) step();
    alloc_if.i_alloc    = 1'b0;
    alloc_if.i_free_vld = 1'b1;
    alloc_if.i_free_ptr = 6'd2;
    step();
    alloc_if.i_free_ptr = 6'd0;
    step();
    alloc_if.i_free_vld = 1'b0;
    chk("wrap_cnt", 32'(alloc_if.o_free_cnt_r), 62);
    chk("wrap_head", 32'(alloc_if.o_alloc_ptr), 4);
    alloc_if.i_alloc = 1'b1;
    for (int i = 4; i < 64; i++) step();
    chk("wrap_first", 32'(alloc_if.o_alloc_ptr), 2);
    step();
    chk("wrap_second", 32'(alloc_if.o_alloc_ptr), 0);
    step();
    alloc_if.i_alloc = 1'b0;
    chk("wrap_vld", 32'(alloc_if.o_alloc_vld), 0);
    chk("wrap_err", 32'(alloc_if.o_err_r), 0);

    // Free 10..19 to reach cnt=10, then alloc + free(5) in the same cycle
    alloc_if.i_free_vld = 1'b1;
    for (int i = 10; i < 20; i++) begin
      alloc_if.i_free_ptr = 6'(i);
      step();
    end
    chk("sim_pre_cnt", 32'(alloc_if.o_free_cnt_r), 10);
    chk("sim_pre_ptr", 32'(alloc_if.o_alloc_ptr), 10);
    alloc_if.i_alloc    = 1'b1;
    alloc_if.i_free_ptr = 6'd5;
    step();
    alloc_if.i_free_vld = 1'b0;
    alloc_if.i_alloc    = 1'b0;
    chk("sim_cnt", 32'(alloc_if.o_free_cnt_r), 10);
    chk("sim_head", 32'(alloc_if.o_alloc_ptr), 11);
    alloc_if.i_alloc = 1'b1;
    repeat (9) step();
    chk("sim_tail", 32'(alloc_if.o_alloc_ptr), 5);
    step();
    alloc_if.i_alloc = 1'b0;
    chk("sim_drain_cnt", 32'(alloc_if.o_free_cnt_r), 0);
    chk("sim_err", 32'(alloc_if.o_err_r), 0);

    // Double free of 7, then alloc-on-empty keeps the first cause
    alloc_if.i_free_vld = 1'b1;
    alloc_if.i_free_ptr = 6'd7;
    step();
    chk("df_first_cnt", 32'(alloc_if.o_free_cnt_r), 1);
    chk("df_first_err", 32'(alloc_if.o_err_r), 0);
    step();
    alloc_if.i_free_vld = 1'b0;
    chk("df_err", 32'(alloc_if.o_err_r), 1);
    chk("df_code", 32'(alloc_if.o_err_code_r), 2);
    chk("df_cnt", 32'(alloc_if.o_free_cnt_r), 1);
    chk("df_ptr", 32'(alloc_if.o_alloc_ptr), 7);
    alloc_if.i_alloc = 1'b1;
    step();
    chk("df_alloc_cnt", 32'(alloc_if.o_free_cnt_r), 0);
    step();
    alloc_if.i_alloc = 1'b0;
    chk("df_sticky_code", 32'(alloc_if.o_err_code_r), 2);
    chk("df_sticky_cnt", 32'(alloc_if.o_free_cnt_r), 0);

    // Free during init raises cause 3 and init carries on
    arst_n = 1'b0;
    #2;
    chk("rr_err_clr", 32'(alloc_if.o_err_r), 0);
    arst_n = 1'b1;
    repeat (10) step();
    alloc_if.i_free_vld = 1'b1;
    alloc_if.i_free_ptr = 6'd3;
    step();
    alloc_if.i_free_vld = 1'b0;
    chk("fi_err", 32'(alloc_if.o_err_r), 1);
    chk("fi_code", 32'(alloc_if.o_err_code_r), 3);
    chk("fi_cnt", 32'(alloc_if.o_free_cnt_r), 11);
    repeat (53) step();
    chk("fi_done_vld", 32'(alloc_if.o_alloc_vld), 1);
    chk("fi_done_cnt", 32'(alloc_if.o_free_cnt_r), 64);

    // Reset mid-run at cnt=20 forgets everything and reruns init
    alloc_if.i_alloc = 1'b1;
    repeat (44) step();
    alloc_if.i_alloc = 1'b0;
    chk("mr_pre_cnt", 32'(alloc_if.o_free_cnt_r), 20);
    arst_n = 1'b0;
    #1;
    chk("mr_cnt", 32'(alloc_if.o_free_cnt_r), 0);
    chk("mr_err", 32'(alloc_if.o_err_r), 0);
    chk("mr_code", 32'(alloc_if.o_err_code_r), 0);
    chk("mr_vld", 32'(alloc_if.o_alloc_vld), 0);
    chk("mr_done", 32'(alloc_if.o_init_done_r), 0);
    #1;
    arst_n = 1'b1;
    repeat (63) step();
    chk("mr63_vld", 32'(alloc_if.o_alloc_vld), 0);
    step();
    chk("mr64_vld", 32'(alloc_if.o_alloc_vld), 1);
    chk("mr64_cnt", 32'(alloc_if.o_free_cnt_r), 64);
    chk("mr64_ptr", 32'(alloc_if.o_alloc_ptr), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
